exec_step_ctrl: RTL and testbench

- Execution-rate controller for the Fibonacci processor. Replaces a free-running slow clock with single-cycle step enables on the system clock.
- Provides run, single-step and halt control, a runtime-programmable step period, a step counter and an LED heartbeat.
- Sits between the board buttons/switches and the processor's clock-enable input.

---
 rtl/exec_step_ctrl.sv | 141 ++++++++++++++
 tb/tb_exec_step_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/exec_step_ctrl.sv
// Execution-rate controller: turns run/step/halt controls into single-cycle
// processor advance enables with a programmable period, step counter and heartbeat.
module exec_step_ctrl #(
    parameter int DIV_WIDTH   = 26,
    parameter int DEFAULT_DIV = 900000,
    parameter int STEP_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_i,
    input  logic                 step_i,
    input  logic                 halt_i,
    input  logic                 div_load_i,
    input  logic [DIV_WIDTH-1:0] div_val_i,
    output logic                 step_en_o,
    output logic                 busy_o,
    output logic [1:0]           state_o,
    output logic [STEP_W-1:0]    step_count_o,
    output logic                 tick_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SINGLE = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO  = {DIV_WIDTH{1'b0}};

    state_t                r_state;
    logic [DIV_WIDTH-1:0]  r_period;
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic                  r_step_prev;
    logic                  r_step_en;
    logic [STEP_W-1:0]     r_step_count;
    logic                  r_tick;

    state_t                w_state_nxt;
    logic [DIV_WIDTH-1:0]  w_period_nxt;
    logic [DIV_WIDTH-1:0]  w_cnt_nxt;
    logic [DIV_WIDTH-1:0]  w_div_val_sat;
    logic                  w_pulse_nxt;
    logic                  w_step_edge;
    logic                  w_terminal;

    assign w_step_edge   = step_i & ~r_step_prev;
    assign w_terminal    = (r_cnt == (r_period - DIV_ONE));
    // A period of 0 is meaningless; treat it like 1 (step every cycle).
    assign w_div_val_sat = (div_val_i <= DIV_ONE) ? DIV_ONE : div_val_i;

    // Next-state, counter, period and pulse decision.
    always_comb begin
        w_state_nxt  = r_state;
        w_period_nxt = r_period;
        w_cnt_nxt    = DIV_ZERO;
        w_pulse_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (halt_i) begin
                    w_state_nxt = ST_HALTED;
                end else if (run_i) begin
                    w_state_nxt = ST_RUN;
                end else if (w_step_edge) begin
                    w_state_nxt = ST_SINGLE;
                    w_pulse_nxt = 1'b1;
                end else if (div_load_i) begin
                    w_period_nxt = w_div_val_sat;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halt_i) begin
                    w_state_nxt = ST_HALTED;
                end else if (!run_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_terminal) begin
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + DIV_ONE;
                end
            end
            ST_SINGLE: begin
                if (halt_i) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HALTED: begin
                // A still-closed run switch must not restart the processor.
                if (!halt_i && !run_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (div_load_i) begin
                    w_period_nxt = w_div_val_sat;
                end else begin
                    w_state_nxt = ST_HALTED;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_period     <= DIV_RESET;
            r_cnt        <= DIV_ZERO;
            r_step_prev  <= 1'b0;
            r_step_en    <= 1'b0;
            r_step_count <= {STEP_W{1'b0}};
            r_tick       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_period    <= w_period_nxt;
            r_cnt       <= w_cnt_nxt;
            r_step_prev <= step_i;
            r_step_en   <= w_pulse_nxt;
            if (w_pulse_nxt) begin
                r_step_count <= r_step_count + STEP_W'(1);
                r_tick       <= ~r_tick;
            end else begin
                r_step_count <= r_step_count;
                r_tick       <= r_tick;
            end
        end
    end

    assign step_en_o    = r_step_en;
    assign busy_o       = (r_state == ST_RUN) || (r_state == ST_SINGLE);
    assign state_o      = r_state;
    assign step_count_o = r_step_count;
    assign tick_o       = r_tick;

endmodule

// File: tb/tb_exec_step_ctrl.sv
// Directed testbench for exec_step_ctrl with a short reset period and 4-bit step counter.
module tb_exec_step_ctrl;

    localparam int DW = 26;

    logic          clk;
    logic          rst;
    logic          run_i;
    logic          step_i;
    logic          halt_i;
    logic          div_load_i;
    logic [DW-1:0] div_val_i;
    logic          step_en_o;
    logic          busy_o;
    logic [1:0]    state_o;
    logic [3:0]    step_count_o;
    logic          tick_o;

    int       n_pass;
    int       n_total;
    logic [3:0] exp_cnt;
    logic       exp_tick;

    exec_step_ctrl #(.DIV_WIDTH(DW), .DEFAULT_DIV(6), .STEP_W(4)) dut (
        .clk(clk), .rst(rst), .run_i(run_i), .step_i(step_i), .halt_i(halt_i),
        .div_load_i(div_load_i), .div_val_i(div_val_i), .step_en_o(step_en_o),
        .busy_o(busy_o), .state_o(state_o), .step_count_o(step_count_o), .tick_o(tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic note_pulse();
        exp_cnt  = exp_cnt + 4'd1;
        exp_tick = ~exp_tick;
    endtask

    task automatic load_div(input logic [DW-1:0] v);
        div_load_i = 1'b1;
        div_val_i  = v;
        cyc();
        div_load_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run_i = 1'b0; step_i = 1'b0; halt_i = 1'b0;
        div_load_i = 1'b0; div_val_i = '0;
        cyc(); cyc();
        exp_cnt = 4'd0; exp_tick = 1'b0;
        n_total++; if (state_o !== 2'd0) $display("FAIL reset_state got %0d exp 0", state_o); else n_pass++;
        n_total++; if (step_en_o !== 1'b0) $display("FAIL reset_en got %b exp 0", step_en_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_o); else n_pass++;
        n_total++; if (step_count_o !== 4'd0) $display("FAIL reset_count got %0d exp 0", step_count_o); else n_pass++;
        n_total++; if (tick_o !== 1'b0) $display("FAIL reset_tick got %b exp 0", tick_o); else n_pass++;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_run_period();
        logic e;
        load_div(26'd4);
        run_i = 1'b1;
        cyc();
        n_total++; if (state_o !== 2'd1) $display("FAIL run_entry_state got %0d exp 1", state_o); else n_pass++;
        n_total++; if (busy_o !== 1'b1) $display("FAIL run_busy got %b exp 1", busy_o); else n_pass++;
        for (int i = 1; i < 20; i++) begin
            cyc();
            e = ((i % 4) == 0);
            if (e) note_pulse();
            n_total++; if (step_en_o !== e) $display("FAIL run_pulse cyc%0d got %b exp %b", i, step_en_o, e); else n_pass++;
        end
        n_total++; if (step_count_o !== 4'd4) $display("FAIL run_count got %0d exp 4", step_count_o); else n_pass++;
        n_total++; if (tick_o !== 1'b0) $display("FAIL run_tick got %b exp 0", tick_o); else n_pass++;
        run_i = 1'b0;
        cyc();
        n_total++; if (state_o !== 2'd0) $display("FAIL run_exit got %0d exp 0", state_o); else n_pass++;
    endtask

    task automatic test_single();
        step_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (i == 1) begin
                note_pulse();
                n_total++; if (state_o !== 2'd2) $display("FAIL single_state cyc%0d got %0d exp 2", i, state_o); else n_pass++;
                n_total++; if (step_en_o !== 1'b1) $display("FAIL single_en cyc%0d got %b exp 1", i, step_en_o); else n_pass++;
            end else begin
                n_total++; if (state_o !== 2'd0) $display("FAIL single_state cyc%0d got %0d exp 0", i, state_o); else n_pass++;
                n_total++; if (step_en_o !== 1'b0) $display("FAIL single_en cyc%0d got %b exp 0", i, step_en_o); else n_pass++;
            end
        end
        n_total++; if (step_count_o !== exp_cnt) $display("FAIL single_count got %0d exp %0d", step_count_o, exp_cnt); else n_pass++;
        step_i = 1'b0;
        cyc();
        step_i = 1'b1;
        cyc();
        note_pulse();
        n_total++; if (step_en_o !== 1'b1) $display("FAIL single_second got %b exp 1", step_en_o); else n_pass++;
        n_total++; if (step_count_o !== exp_cnt) $display("FAIL single_count2 got %0d exp %0d", step_count_o, exp_cnt); else n_pass++;
        n_total++; if (tick_o !== exp_tick) $display("FAIL single_tick got %b exp %b", tick_o, exp_tick); else n_pass++;
        step_i = 1'b0;
        cyc();
    endtask

    task automatic test_halt();
        run_i = 1'b1;
        cyc();
        cyc(); cyc(); cyc();
        halt_i = 1'b1;
        cyc();
        n_total++; if (state_o !== 2'd3) $display("FAIL halt_state got %0d exp 3", state_o); else n_pass++;
        n_total++; if (step_en_o !== 1'b0) $display("FAIL halt_nopulse got %b exp 0", step_en_o); else n_pass++;
        n_total++; if (step_count_o !== exp_cnt) $display("FAIL halt_count got %0d exp %0d", step_count_o, exp_cnt); else n_pass++;
        halt_i = 1'b0;
        step_i = 1'b1;
        cyc();
        n_total++; if (state_o !== 2'd3) $display("FAIL halt_hold got %0d exp 3", state_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL halt_busy got %b exp 0", busy_o); else n_pass++;
        step_i = 1'b0;
        run_i  = 1'b0;
        cyc();
        n_total++; if (state_o !== 2'd0) $display("FAIL halt_release got %0d exp 0", state_o); else n_pass++;
    endtask

    task automatic test_fast_period();
        load_div(26'd0);
        run_i = 1'b1;
        cyc();
        n_total++; if (step_en_o !== 1'b0) $display("FAIL fast_entry got %b exp 0", step_en_o); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cyc();
            note_pulse();
            n_total++; if (step_en_o !== 1'b1) $display("FAIL fast_en cyc%0d got %b exp 1", i, step_en_o); else n_pass++;
        end
        div_load_i = 1'b1;
        div_val_i  = 26'd8;
        cyc();
        note_pulse();
        div_load_i = 1'b0;
        n_total++; if (step_en_o !== 1'b1) $display("FAIL fast_load_run got %b exp 1", step_en_o); else n_pass++;
        cyc();
        note_pulse();
        n_total++; if (step_en_o !== 1'b1) $display("FAIL fast_period_kept got %b exp 1", step_en_o); else n_pass++;
        n_total++; if (step_count_o !== exp_cnt) $display("FAIL fast_count got %0d exp %0d", step_count_o, exp_cnt); else n_pass++;
        run_i = 1'b0;
        cyc();
        n_total++; if (step_en_o !== 1'b0) $display("FAIL fast_stop got %b exp 0", step_en_o); else n_pass++;
    endtask

    task automatic test_wrap();
        int guard;
        guard = 0;
        run_i = 1'b1;
        cyc();
        while (exp_cnt != 4'hF && guard < 40) begin
            cyc();
            note_pulse();
            guard++;
        end
        n_total++; if (step_count_o !== 4'hF) $display("FAIL wrap_full got %0d exp 15", step_count_o); else n_pass++;
        cyc();
        note_pulse();
        n_total++; if (step_count_o !== 4'h0) $display("FAIL wrap_zero got %0d exp 0", step_count_o); else n_pass++;
        n_total++; if (tick_o !== exp_tick) $display("FAIL wrap_tick got %b exp %b", tick_o, exp_tick); else n_pass++;
        run_i = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_run();
        logic e;
        load_div(26'd4);
        run_i = 1'b1;
        cyc();
        cyc(); cyc(); cyc();
        rst = 1'b1;
        cyc();
        exp_cnt = 4'd0; exp_tick = 1'b0;
        n_total++; if (step_en_o !== 1'b0) $display("FAIL rstmid_en got %b exp 0", step_en_o); else n_pass++;
        n_total++; if (state_o !== 2'd0) $display("FAIL rstmid_state got %0d exp 0", state_o); else n_pass++;
        n_total++; if (step_count_o !== 4'd0) $display("FAIL rstmid_count got %0d exp 0", step_count_o); else n_pass++;
        n_total++; if (tick_o !== 1'b0) $display("FAIL rstmid_tick got %b exp 0", tick_o); else n_pass++;
        rst = 1'b0;
        cyc();
        n_total++; if (step_en_o !== 1'b0) $display("FAIL rstmid_after got %b exp 0", step_en_o); else n_pass++;
        n_total++; if (state_o !== 2'd1) $display("FAIL rstmid_rerun got %0d exp 1", state_o); else n_pass++;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            e = (i == 6);
            n_total++; if (step_en_o !== e) $display("FAIL rstmid_default_div cyc%0d got %b exp %b", i, step_en_o, e); else n_pass++;
        end
        run_i = 1'b0;
        cyc();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_run_period();
        test_single();
        test_halt();
        test_fast_period();
        test_wrap();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
